// File: rtl/lstm_seq_ctrl.sv
// lstm_seq_ctrl: steps one LSTM layer over a sequence of input vectors and owns the recurrent h/c state
// Ports:
//   clk, rst (async, active-low)
//   i_start/i_len                 start a sequence of i_len steps (sampled in IDLE)
//   i_x_valid/o_x_ready/i_x       input vector stream
//   o_cell_x/o_cell_prev_state    to the cell: {h_reg, x_reg} and c_reg
//   i_cell_h/i_cell_c             cell results, sampled CELL_LAT edges after x_reg loads
//   o_h_valid/i_h_ready/o_h       output hidden-state stream, o_last on the final step
//   o_busy, o_done                status; o_done is a one-cycle completion pulse
// Optional feature macro LSTM_STATE_CARRY_EN adds i_keep to retain h/c across sequences.
module lstm_seq_ctrl #(
  parameter int WIDTH    = 32,
  parameter int NUM      = 2,
  parameter int NUM_LSTM = 1,
  parameter int CELL_LAT = 2,
  parameter int LEN_W    = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_start,
  input  logic [LEN_W-1:0]                 i_len,
`ifdef LSTM_STATE_CARRY_EN
  input  logic                             i_keep,
`endif
  input  logic                             i_x_valid,
  output logic                             o_x_ready,
  input  logic [NUM*WIDTH-1:0]             i_x,
  output logic [(NUM+NUM_LSTM)*WIDTH-1:0]  o_cell_x,
  output logic [NUM_LSTM*WIDTH-1:0]        o_cell_prev_state,
  input  logic [NUM_LSTM*WIDTH-1:0]        i_cell_h,
  input  logic [NUM_LSTM*WIDTH-1:0]        i_cell_c,
  output logic                             o_h_valid,
  input  logic                             i_h_ready,
  output logic [NUM_LSTM*WIDTH-1:0]        o_h,
  output logic                             o_last,
  output logic                             o_busy,
  output logic                             o_done
);
  typedef enum logic [1:0] {IDLE, WAIT_X, RUN, OUT} state_t;
  state_t                      state_q;
  logic [NUM_LSTM*WIDTH-1:0]   h_q, c_q;
  logic [NUM*WIDTH-1:0]        x_q;
  logic [LEN_W-1:0]            rem_q;
  logic [3:0]                  cnt_q;
  logic                        done_q;
  logic                        keep_d;
`ifdef LSTM_STATE_CARRY_EN
  assign keep_d = i_keep;
`else
  assign keep_d = 1'b0;
`endif
  assign o_x_ready         = state_q == WAIT_X;
  assign o_h_valid         = state_q == OUT;
  assign o_busy            = state_q != IDLE;
  assign o_h               = h_q;
  assign o_last            = o_h_valid && rem_q == LEN_W'(1);
  assign o_cell_x          = {h_q, x_q};
  assign o_cell_prev_state = c_q;
  // the zero-length case pulses one cycle late (registered); the final handshake pulses in the same cycle
  assign o_done            = done_q | (o_last & i_h_ready);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      h_q     <= '0;
      c_q     <= '0;
      x_q     <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (i_start) begin
          if (i_len != '0) begin
            if (!keep_d) begin
              h_q <= '0;
              c_q <= '0;
            end
            rem_q   <= i_len;
            state_q <= WAIT_X;
          end else begin
            done_q <= 1'b1;
          end
        end
        WAIT_X: if (i_x_valid) begin
          x_q     <= i_x;
          cnt_q   <= '0;
          state_q <= RUN;
        end
        RUN: begin
          cnt_q <= cnt_q + 4'd1;
          // cell outputs are stable by the CELL_LAT-th edge after x_reg loaded
          if (cnt_q == 4'(CELL_LAT - 1)) begin
            h_q     <= i_cell_h;
            c_q     <= i_cell_c;
            state_q <= OUT;
          end
        end
        OUT: if (i_h_ready) begin
          rem_q   <= rem_q - LEN_W'(1);
          state_q <= rem_q == LEN_W'(1) ? IDLE : WAIT_X;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/lstm_seq_ctrl.md
Name: lstm_seq_ctrl

Overview:
Sequencer that steps one LSTM layer (lstm_cell instances, NUM inputs, NUM_LSTM cells) over a time sequence of input vectors.
- Accepts x_t on a valid/ready input stream.
- Builds the cell's concatenated input {h_(t-1), x_t} and drives the previous cell state c_(t-1).
- Waits a fixed cell latency, captures h_t/c_t into feedback registers and emits h_t on a valid/ready output stream.
- Sits between the input buffer and the layer datapath; owns the recurrent h/c state that the cell itself does not hold.

Parameters:
WIDTH, 32, fixed-point word width (Q8.24; 32'h01000000 = 1.0)
NUM, 2, number of input words per time step
NUM_LSTM, 1, number of LSTM cells (hidden words) in the layer
CELL_LAT, 2, clock edges from stable o_cell_x to valid i_cell_h/i_cell_c; legal range 1..15
LEN_W, 8, width of the sequence length field

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
i_start  in  1  start a new sequence; sampled in IDLE only
i_len  in  LEN_W  number of time steps, latched on accepted i_start
i_x_valid  in  1  input vector valid
o_x_ready  out  1  controller accepts x_t this cycle
i_x  in  NUM*WIDTH  input vector x_t
o_cell_x  out  (NUM+NUM_LSTM)*WIDTH  to cell i_x: {h_reg, x_reg}, h in the MSBs
o_cell_prev_state  out  NUM_LSTM*WIDTH  to cell i_prev_state: c_reg
i_cell_h  in  NUM_LSTM*WIDTH  cell o_h
i_cell_c  in  NUM_LSTM*WIDTH  cell o_c
o_h_valid  out  1  output h_t valid
i_h_ready  in  1  downstream accepts h_t
o_h  out  NUM_LSTM*WIDTH  h_t
o_last  out  1  high with o_h_valid on the final step
o_busy  out  1  high in any state other than IDLE
o_done  out  1  one-cycle pulse when the sequence completes

Behaviour:
- Reset (rst=0, async): state=IDLE; h_reg, c_reg, x_reg, remaining count, latency counter = 0; all outputs 0. Applies mid-sequence as well; the in-flight step is discarded.
- FSM states: IDLE, WAIT_X, RUN, OUT.
- IDLE:
  - i_start=1 and i_len!=0: clear h_reg/c_reg, load remaining=i_len, go to WAIT_X.
  - i_start=1 and i_len=0: stay in IDLE; o_done pulses the next cycle.
- WAIT_X:
  - o_x_ready=1.
  - On i_x_valid & o_x_ready: x_reg<=i_x, latency counter<=0, go to RUN.
- RUN:
  - o_x_ready=0; o_cell_x and o_cell_prev_state are held stable.
  - The counter increments each cycle. On the cycle the counter equals CELL_LAT-1: h_reg<=i_cell_h, c_reg<=i_cell_c, go to OUT.
  - Net effect: i_cell_h/i_cell_c are sampled CELL_LAT edges after x_reg loads.
- OUT:
  - o_h_valid=1, o_h=h_reg, o_last=(remaining==1).
  - Output is held until i_h_ready. On the handshake, remaining decrements.
  - If remaining was 1: o_done pulses the same cycle and the FSM goes to IDLE. Otherwise it goes to WAIT_X.
- o_cell_x and o_cell_prev_state are always combinational from the registers. Step t therefore sees h_(t-1)/c_(t-1), and step 0 sees zeros.
- i_start outside IDLE is ignored (no abort). i_x_valid outside WAIT_X is ignored. o_h_valid never drops without a handshake.
- Minimum step period: 1 (accept) + CELL_LAT + 1 (output) cycles, with i_h_ready held high.
- No arithmetic is performed; words pass through unchanged (no saturation, no reordering).

Optional Feature:
LSTM_STATE_CARRY_EN
- Defined: adds input port i_keep (1 bit). An accepted i_start with i_keep=1 retains h_reg/c_reg from the previous sequence (stateful streaming); i_keep=0 clears them.
- Not defined: no i_keep port; every accepted i_start clears h_reg/c_reg to 0.

Test Plan:
- Reset then i_start, i_len=2, x_0=64'h02000000_01000000 -> o_cell_x=96'h00000000_02000000_01000000, o_cell_prev_state=0; o_h_valid rises exactly CELL_LAT+1 cycles after the x handshake.
- Continue step 0 with cell model returning h=32'h00894b9c, c=32'h00ca01f1; x_1=64'h03000000_00800000 -> o_cell_x=96'h00894b9c_03000000_00800000, o_cell_prev_state=32'h00ca01f1; o_last=1 on step 1; o_done one pulse; o_busy falls.
- Hold i_h_ready=0 for 5 cycles in OUT -> o_h_valid and o_h stay stable, o_x_ready=0; single handshake on release.
- i_len=0 -> no o_x_ready, o_busy stays 0, o_done pulses once. Separately, i_start pulsed mid-sequence -> ignored, remaining count unchanged.
- Assert rst=0 in RUN -> all outputs 0 immediately (async). A new sequence after release starts with h/c=0.
- With LSTM_STATE_CARRY_EN: second sequence with i_keep=1 -> first o_cell_x MSB word=32'h00894b9c (carried h). With i_keep=0 -> 0.
